// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write arbiter: default geometry,
// arbiter state encoding and a counter-width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package fb_pkg;

   // Pixel address is row[8:5], col[4:0]; the framebuffer adds one MSB
   // to select between the front and back halves.
   localparam int FB_ADDR_W    = 9;
   localparam int FB_DATA_W    = 24;
   localparam int FB_BURST_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_t;

   // Width of a counter that must hold 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Next-grant decision for the two-port framebuffer write arbiter.
// Latency: combinational. Backpressure: block forces IDLE so no new grant is issued.
//
// Ports:
//   req0/req1   - write requests from the two ports
//   ptr         - preferred port on a tie (0 = port 0, 1 = port 1)
//   block       - a buffer swap is waiting; release and hold off grants
//   burst_done  - the current owner's last beat of its burst window is accepted now
//   state       - current arbiter state
//   next_state  - arbiter state for the next cycle
module fb_rr_pick import fb_pkg::*; (
   input  logic       req0,
   input  logic       req1,
   input  logic       ptr,
   input  logic       block,
   input  logic       burst_done,
   input  arb_state_t state,
   output arb_state_t next_state
);

   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE: begin
            if (block)
               next_state = ST_IDLE;
            else if (req0 && req1)
               next_state = ptr ? ST_GNT1 : ST_GNT0;
            else if (req0)
               next_state = ST_GNT0;
            else if (req1)
               next_state = ST_GNT1;
            else
               next_state = ST_IDLE;
         end
         ST_GNT0: begin
            // A pending swap wins over everything: drain the write path so
            // the swap can land on a quiet vsync.
            if (block || !req0)
               next_state = ST_IDLE;
            else if (burst_done && req1)
               next_state = ST_GNT1;
            else
               next_state = ST_GNT0;
         end
         ST_GNT1: begin
            if (block || !req1)
               next_state = ST_IDLE;
            else if (burst_done && req0)
               next_state = ST_GNT0;
            else
               next_state = ST_GNT1;
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/fb_write_arb.sv
// Two-port framebuffer write arbiter with double-buffer swap on vsync.
// Latency: grant 1 cycle after request; accepted beat reaches fb_* 1 cycle later.
// Backpressure: a port only writes while its grant is high; a pending swap withholds grants.
//
// Ports:
//   pixclk, reset          - clock, synchronous active-high reset
//   req0/1, addr0/1, rgb0/1 - write beats from the two requesters
//   grant0/1               - registered grants; beat accepted when reqN & grantN
//   swap_req, vsync        - back buffer complete / scanout frame boundary pulses
//   fb_we, fb_addr, fb_rgb - framebuffer write port, fb_addr MSB selects the back half
//   display, swap_pending, swap_ack - shown half, swap waiting, swap-done pulse
module fb_write_arb import fb_pkg::*; #(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int BURST_MAX = FB_BURST_MAX
) (
   input  logic              pixclk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] rgb0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] rgb1,
   output logic              grant0,
   output logic              grant1,
   input  logic              swap_req,
   input  logic              vsync,
   output logic              fb_we,
   output logic [ADDR_W:0]   fb_addr,
   output logic [DATA_W-1:0] fb_rgb,
   output logic              display,
   output logic              swap_pending,
   output logic              swap_ack
);

   localparam int              CNT_W     = cnt_width(BURST_MAX);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

   typedef struct packed {
      logic [ADDR_W:0]   addr;
      logic [DATA_W-1:0] rgb;
   } wr_beat_t;

   arb_state_t       state;
   arb_state_t       next_state;
   logic             ptr;
   logic [CNT_W-1:0] beat_cnt;
   logic             acc0;
   logic             acc1;
   logic             acc_any;
   logic             burst_done;
   wr_beat_t         sel_beat;

   assign acc0       = grant0 & req0;
   assign acc1       = grant1 & req1;
   assign acc_any    = acc0 | acc1;
   assign burst_done = acc_any && (beat_cnt == LAST_BEAT);

   fb_rr_pick u_pick (
      .req0       (req0),
      .req1       (req1),
      .ptr        (ptr),
      .block      (swap_pending),
      .burst_done (burst_done),
      .state      (state),
      .next_state (next_state)
   );

   // Arbiter state, registered grants, round-robin pointer and burst counter.
   always_ff @(posedge pixclk) begin
      if (reset) begin
         state    <= ST_IDLE;
         grant0   <= 1'b0;
         grant1   <= 1'b0;
         ptr      <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state  <= next_state;
         grant0 <= (next_state == ST_GNT0);
         grant1 <= (next_state == ST_GNT1);

         // Pointer always names the port that was not granted most recently.
         if (next_state == ST_GNT0)
            ptr <= 1'b1;
         else if (next_state == ST_GNT1)
            ptr <= 1'b0;

         // Counter restarts on every ownership change; when the owner keeps
         // the bus past a full window (other port quiet) it wraps to start a
         // fresh window so the other port is not starved later.
         if (next_state != state)
            beat_cnt <= '0;
         else if (acc_any)
            beat_cnt <= burst_done ? '0 : beat_cnt + 1'b1;
      end
   end

   // Beat mux: grants are exclusive, so at most one of acc0/acc1 is set.
   // The MSB targets the half that is not being displayed.
   always_comb begin
      sel_beat.addr = {~display, addr0};
      sel_beat.rgb  = rgb0;
      if (acc1) begin
         sel_beat.addr = {~display, addr1};
         sel_beat.rgb  = rgb1;
      end
   end

   // Framebuffer write port, one cycle behind acceptance. Address/data hold
   // their last value while fb_we is low.
   always_ff @(posedge pixclk) begin
      if (reset) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_rgb  <= '0;
      end else begin
         fb_we <= acc_any;
         if (acc_any) begin
            fb_addr <= sel_beat.addr;
            fb_rgb  <= sel_beat.rgb;
         end
      end
   end

   // Swap control. The swap only lands on a vsync with no write in flight
   // on the framebuffer port; otherwise it waits for a later vsync. A
   // swap_req that arrives with vsync while nothing is pending only arms it.
   always_ff @(posedge pixclk) begin
      if (reset) begin
         display      <= 1'b0;
         swap_pending <= 1'b0;
         swap_ack     <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         if (vsync && swap_pending && !fb_we) begin
            display      <= ~display;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b1;
         end else if (swap_req && !swap_pending) begin
            swap_pending <= 1'b1;
         end
      end
   end

   grants_exclusive: assert property (@(posedge pixclk) disable iff (reset) !(grant0 && grant1));

endmodule

// File: tb/tb_fb_write_arb.sv
// Self-checking bench for fb_write_arb: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_fb_write_arb;

   localparam int AW    = 9;
   localparam int DW    = 24;
   localparam int BURST = 32;

   logic          pixclk;
   logic          reset;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] rgb0, rgb1;
   logic          grant0, grant1;
   logic          swap_req, vsync;
   logic          fb_we;
   logic [AW:0]   fb_addr;
   logic [DW-1:0] fb_rgb;
   logic          display, swap_pending, swap_ack;

   fb_write_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BURST)) dut (
      .pixclk       (pixclk),
      .reset        (reset),
      .req0         (req0),
      .addr0        (addr0),
      .rgb0         (rgb0),
      .req1         (req1),
      .addr1        (addr1),
      .rgb1         (rgb1),
      .grant0       (grant0),
      .grant1       (grant1),
      .swap_req     (swap_req),
      .vsync        (vsync),
      .fb_we        (fb_we),
      .fb_addr      (fb_addr),
      .fb_rgb       (fb_rgb),
      .display      (display),
      .swap_pending (swap_pending),
      .swap_ack     (swap_ack)
   );

   initial pixclk = 1'b0;
   always #5 pixclk = ~pixclk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: who owns the bus (-1 none), beats in the current
   // window, who was granted last, and the expected registered outputs.
   int            m_owner = -1;
   int            m_run   = 0;
   int            m_last  = 1;
   bit            m_pend  = 0;
   bit            m_disp  = 0;
   bit            m_ack   = 0;
   bit            m_we    = 0;
   logic [AW:0]   m_addr  = '0;
   logic [DW-1:0] m_rgb   = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model across one rising edge using the inputs now driven.
   task automatic model_step();
      int  acc;
      int  nxt;
      bit  old_pend;
      bit  old_we;
      bit  rq [2];
      if (reset) begin
         m_owner = -1; m_run = 0; m_last = 1;
         m_pend = 0; m_disp = 0; m_ack = 0; m_we = 0;
         m_addr = '0; m_rgb = '0;
         return;
      end
      rq[0] = req0;
      rq[1] = req1;
      old_pend = m_pend;
      old_we   = m_we;

      acc = -1;
      if (m_owner >= 0 && rq[m_owner]) acc = m_owner;
      m_we = (acc >= 0);
      if (acc == 0) begin m_addr = {~m_disp, addr0}; m_rgb = rgb0; end
      if (acc == 1) begin m_addr = {~m_disp, addr1}; m_rgb = rgb1; end

      if (m_owner < 0) begin
         if (!old_pend && (req0 || req1)) begin
            nxt = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
            m_owner = nxt; m_last = nxt; m_run = 0;
         end
      end else if (old_pend || acc < 0) begin
         m_owner = -1; m_run = 0;
      end else begin
         m_run++;
         if (m_run == BURST) begin
            m_run = 0;
            if (rq[1 - m_owner]) begin
               m_owner = 1 - m_owner;
               m_last  = m_owner;
            end
         end
      end

      m_ack = 0;
      if (vsync && old_pend && !old_we) begin
         m_disp = ~m_disp; m_pend = 0; m_ack = 1;
      end else if (swap_req && !old_pend) begin
         m_pend = 1;
      end
   endtask

   task automatic compare_all();
      chk("grant0", grant0, m_owner == 0);
      chk("grant1", grant1, m_owner == 1);
      chk("grant_overlap", grant0 & grant1, 0);
      chk("fb_we", fb_we, m_we);
      chk("fb_addr", fb_addr, m_addr);
      chk("fb_rgb", fb_rgb, m_rgb);
      chk("display", display, m_disp);
      chk("swap_pending", swap_pending, m_pend);
      chk("swap_ack", swap_ack, m_ack);
   endtask

   // One clock: model update, edge, sample on the falling edge, clear pulses.
   task automatic tick();
      model_step();
      @(posedge pixclk);
      @(negedge pixclk);
      swap_req = 1'b0;
      vsync    = 1'b0;
      reset    = 1'b0;
      compare_all();
   endtask

   initial begin
      int cur_port, cur_len, runs, p, held;
      int pr0, pr1;

      reset = 1'b1; req0 = 0; req1 = 0; swap_req = 0; vsync = 0;
      addr0 = '0; addr1 = '0; rgb0 = '0; rgb1 = '0;
      tick();
      reset = 1'b1;
      tick();
      chk("rst_display", display, 0);
      chk("rst_fb_addr", fb_addr, 0);
      tick();

      // Single write from port 0.
      req0 = 1; addr0 = 9'h005; rgb0 = 24'hFF0000;
      tick();
      chk("r029_grant0", grant0, 1);
      tick();
      chk("r029_we", fb_we, 1);
      chk("r029_addr", fb_addr, 10'h205);
      chk("r029_rgb", fb_rgb, 24'hFF0000);
      req0 = 0;
      tick();
      tick();

      // Both ports held: back-to-back runs of exactly BURST beats.
      req0 = 1; req1 = 1; cur_port = -1; cur_len = 0; runs = 0;
      for (int i = 0; i < 100; i++) begin
         addr0 = AW'($urandom); addr1 = AW'($urandom);
         rgb0 = DW'($urandom); rgb1 = DW'($urandom);
         tick();
         p = grant0 ? 0 : (grant1 ? 1 : -1);
         if (p != cur_port) begin
            if (cur_port >= 0) begin
               chk("r030_run_len", cur_len, BURST);
               chk("r030_direct_handoff", p, 1 - cur_port);
               runs++;
            end
            cur_port = p;
            cur_len  = (p >= 0) ? 1 : 0;
         end else if (p >= 0) begin
            cur_len++;
         end
      end
      chk("r030_runs", runs >= 3, 1);
      req0 = 0; req1 = 0;
      tick(); tick();

      // One port alone keeps the bus past a full window.
      req0 = 1; held = 0;
      for (int i = 0; i < 45; i++) begin
         addr0 = AW'($urandom); rgb0 = DW'($urandom);
         tick();
         if (grant0) held++;
      end
      chk("r018_hold", held, 45);
      req0 = 0;
      tick(); tick();

      // Swap requested during a port-1 run; first vsync is deferred by an
      // in-flight write, the next one lands the swap.
      req1 = 1; addr1 = 9'h0A3; rgb1 = 24'h0000FF;
      tick(); tick(); tick();
      chk("r031_display_before", display, 0);
      swap_req = 1;
      tick();
      chk("r031_pending", swap_pending, 1);
      chk("r031_grant_still", grant1, 1);
      vsync = 1;
      tick();
      chk("r031_grant_drop", grant1, 0);
      chk("r022_defer_display", display, 0);
      chk("r022_defer_pending", swap_pending, 1);
      req1 = 0;
      tick();
      vsync = 1;
      tick();
      chk("r031_display_after", display, 1);
      chk("r031_ack", swap_ack, 1);
      tick();
      chk("r031_ack_single", swap_ack, 0);
      req0 = 1; addr0 = 9'h011; rgb0 = 24'h00FF00;
      tick(); tick();
      chk("r031_new_half", fb_addr, 10'h011);
      req0 = 0;
      tick();

      // swap_req coincident with vsync only arms the swap.
      swap_req = 1; vsync = 1;
      tick();
      chk("r032_no_toggle", display, 1);
      chk("r032_pending", swap_pending, 1);
      tick();
      vsync = 1;
      tick();
      chk("r032_toggle", display, 0);
      tick();

      // Reset mid-burst with a swap pending and display = 1.
      swap_req = 1; tick();
      vsync = 1; tick();
      chk("r033_display_set", display, 1);
      req0 = 1; addr0 = 9'h1FF; rgb0 = 24'hABCDEF;
      tick(); tick();
      swap_req = 1;
      tick();
      chk("r033_pre_grant0", grant0, 1);
      chk("r033_pre_pending", swap_pending, 1);
      reset = 1;
      tick();
      chk("r033_grant0", grant0, 0);
      chk("r033_grant1", grant1, 0);
      chk("r033_fb_we", fb_we, 0);
      chk("r033_fb_addr", fb_addr, 0);
      chk("r033_fb_rgb", fb_rgb, 0);
      chk("r033_display", display, 0);
      chk("r033_pending", swap_pending, 0);
      chk("r033_ack", swap_ack, 0);
      req0 = 0;
      tick();

      // Randomized traffic in phases of differing request density.
      for (int i = 0; i < 4000; i++) begin
         case ((i / 500) % 4)
            0:       begin pr0 = 95; pr1 = 95; end
            1:       begin pr0 = 95; pr1 = 5;  end
            2:       begin pr0 = 50; pr1 = 50; end
            default: begin pr0 = 5;  pr1 = 95; end
         endcase
         req0     = ($urandom_range(0, 99) < pr0);
         req1     = ($urandom_range(0, 99) < pr1);
         addr0    = AW'($urandom);
         addr1    = AW'($urandom);
         rgb0     = DW'($urandom);
         rgb1     = DW'($urandom);
         swap_req = ($urandom_range(0, 99) < 3);
         vsync    = ($urandom_range(0, 99) < 6);
         reset    = ($urandom_range(0, 999) < 3);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
